beam_scan_controller: RTL and testbench

BEAM_SCAN_CONTROLLER -- requirements
Module: beam_scan_controller

---
 rtl/beam_scan_controller.sv | 189 ++++++++++++++++++
 tb/tb_beam_scan_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/beam_scan_controller.sv
// rtl/beam_scan_controller.sv - steps a 12-entry delay table, measures |beam| energy per direction
// and latches the loudest direction once a full scan completes.
module beam_scan_controller #(
  parameter int SETTLE_SAMPLES = 16,
  parameter int WINDOW_LOG2    = 8,
  localparam int ACC_W         = 22 + WINDOW_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [21:0]      beam_sample,
  input  logic                    scan_start,
  input  logic                    scan_abort,
  output logic [4:0]              delay_select,
  output logic [4:0]              best_select,
  output logic [ACC_W-1:0]        best_energy,
  output logic [3:0]              scan_index,
  output logic                    busy,
  output logic                    done
);

  localparam int SW = $clog2(SETTLE_SAMPLES + 1);
  localparam int CW = WINDOW_LOG2 + 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);
  localparam logic [CW-1:0] WINDOW_LAST = CW'((1 << WINDOW_LOG2) - 1);
  localparam logic [3:0]    LAST_INDEX  = 4'd11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    ACCUM   = 2'd2,
    COMPARE = 2'd3
  } state_t;

  // Codes 30/31 are parking values only; the table never reaches them.
  function automatic logic [4:0] dir_code(input logic [3:0] idx);
    case (idx)
      4'd0:    dir_code = 5'd0;
      4'd1:    dir_code = 5'd1;
      4'd2:    dir_code = 5'd5;
      4'd3:    dir_code = 5'd6;
      4'd4:    dir_code = 5'd10;
      4'd5:    dir_code = 5'd11;
      4'd6:    dir_code = 5'd15;
      4'd7:    dir_code = 5'd16;
      4'd8:    dir_code = 5'd20;
      4'd9:    dir_code = 5'd21;
      4'd10:   dir_code = 5'd25;
      4'd11:   dir_code = 5'd26;
      default: dir_code = 5'd30;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       scan_index_q, scan_index_d;
  logic [4:0]       delay_select_q, delay_select_d;
  logic [4:0]       best_select_q, best_select_d;
  logic [ACC_W-1:0] best_energy_q, best_energy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [CW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] cand_energy_q, cand_energy_d;
  logic [4:0]       cand_select_q, cand_select_d;

  logic [21:0]      abs_val;
  logic             take_new;

  // Two's-complement magnitude; -2^21 maps to 2^21 in the 22-bit unsigned result.
  assign abs_val  = beam_sample[21] ? ($unsigned(~beam_sample) + 22'd1) : $unsigned(beam_sample);
  assign take_new = (scan_index_q == 4'd0) || (acc_q > cand_energy_q);

  always_comb begin
    state_d        = state_q;
    scan_index_d   = scan_index_q;
    delay_select_d = delay_select_q;
    best_select_d  = best_select_q;
    best_energy_d  = best_energy_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    settle_cnt_d   = settle_cnt_q;
    sample_cnt_d   = sample_cnt_q;
    acc_d          = acc_q;
    cand_energy_d  = cand_energy_q;
    cand_select_d  = cand_select_q;

    if (state_q != IDLE && scan_abort) begin
      state_d        = IDLE;
      busy_d         = 1'b0;
      delay_select_d = best_select_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (scan_start) begin
            state_d        = SETTLE;
            scan_index_d   = 4'd0;
            delay_select_d = dir_code(4'd0);
            settle_cnt_d   = '0;
            sample_cnt_d   = '0;
            acc_d          = '0;
            busy_d         = 1'b1;
          end
        end
        SETTLE: begin
          if (sample_valid) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              settle_cnt_d = '0;
              state_d      = ACCUM;
            end else begin
              settle_cnt_d = settle_cnt_q + 1'b1;
            end
          end
        end
        ACCUM: begin
          if (sample_valid) begin
            acc_d = acc_q + {{WINDOW_LOG2{1'b0}}, abs_val};
            if (sample_cnt_q == WINDOW_LAST) begin
              sample_cnt_d = '0;
              state_d      = COMPARE;
            end else begin
              sample_cnt_d = sample_cnt_q + 1'b1;
            end
          end
        end
        COMPARE: begin
          if (take_new) begin
            cand_energy_d = acc_q;
            cand_select_d = dir_code(scan_index_q);
          end
          if (scan_index_q == LAST_INDEX) begin
            best_energy_d  = cand_energy_d;
            best_select_d  = cand_select_d;
            delay_select_d = cand_select_d;
            done_d         = 1'b1;
            busy_d         = 1'b0;
            state_d        = IDLE;
          end else begin
            scan_index_d   = scan_index_q + 4'd1;
            delay_select_d = dir_code(scan_index_q + 4'd1);
            settle_cnt_d   = '0;
            sample_cnt_d   = '0;
            acc_d          = '0;
            state_d        = SETTLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      scan_index_q   <= 4'd0;
      delay_select_q <= 5'd30;
      best_select_q  <= 5'd30;
      best_energy_q  <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      settle_cnt_q   <= '0;
      sample_cnt_q   <= '0;
      acc_q          <= '0;
      cand_energy_q  <= '0;
      cand_select_q  <= 5'd0;
    end else begin
      state_q        <= state_d;
      scan_index_q   <= scan_index_d;
      delay_select_q <= delay_select_d;
      best_select_q  <= best_select_d;
      best_energy_q  <= best_energy_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      settle_cnt_q   <= settle_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
      acc_q          <= acc_d;
      cand_energy_q  <= cand_energy_d;
      cand_select_q  <= cand_select_d;
    end
  end

  assign delay_select = delay_select_q;
  assign best_select  = best_select_q;
  assign best_energy  = best_energy_q;
  assign scan_index   = scan_index_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_beam_scan_controller.sv
// tb/tb_beam_scan_controller.sv - scoreboard bench: per-direction beam levels, expected winner queued per scan.
module tb_beam_scan_controller;

  localparam int SETTLE = 4;
  localparam int WL2    = 2;
  localparam int ACC_W  = 22 + WL2;
  localparam int WIN    = 1 << WL2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [21:0] beam_sample = '0;
  logic               scan_start = 1'b0;
  logic               scan_abort = 1'b0;
  logic [4:0]         delay_select, best_select;
  logic [ACC_W-1:0]   best_energy;
  logic [3:0]         scan_index;
  logic               busy, done;

  beam_scan_controller #(.SETTLE_SAMPLES(SETTLE), .WINDOW_LOG2(WL2)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .beam_sample(beam_sample),
    .scan_start(scan_start), .scan_abort(scan_abort), .delay_select(delay_select),
    .best_select(best_select), .best_energy(best_energy), .scan_index(scan_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { longint sel; longint energy; } exp_t;
  exp_t   sb_q[$];
  int     errors = 0;
  int     checks = 0;
  int     dir_val[16];
  int     table_codes[12] = '{0, 1, 5, 6, 10, 11, 15, 16, 20, 21, 25, 26};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: energy = window * |level|, strict '>' so earlier directions win ties.
  function automatic exp_t predict();
    exp_t   r;
    longint e;
    r.sel = 0; r.energy = 0;
    for (int i = 0; i < 12; i++) begin
      e = WIN * ((dir_val[i] < 0) ? -longint'(dir_val[i]) : longint'(dir_val[i]));
      if (i == 0 || e > r.energy) begin
        r.energy = e;
        r.sel    = table_codes[i];
      end
    end
    return r;
  endfunction

  // Sample stream: one strobe every 4th cycle, level chosen by the direction under test.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      sample_valid = (cnt % 4 == 0);
      beam_sample  = 22'(dir_val[scan_index]);
      cnt++;
    end
  end

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (done_prev) chk("done_width", 2, 1);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("best_select", best_select, e.sel);
          chk("best_energy", best_energy, e.energy);
          chk("delay_after_done", delay_select, e.sel);
          chk("busy_after_done", busy, 0);
        end
      end
      done_prev = done;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1; scan_start = 1'b1;
    @(posedge clk); #1; scan_start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_index", scan_index, 0);
    chk("start_delay", delay_select, 0);
  endtask

  task automatic run_scan(input bit interfere);
    bit pulsed = 0;
    int c = 0;
    sb_q.push_back(predict());
    pulse_start();
    while (busy && c < 3000) begin
      if (interfere && !pulsed && scan_index == 4'd2) begin
        pulsed = 1;
        scan_start = 1'b1;
        @(posedge clk); #1; scan_start = 1'b0;
        chk("restart_ignored_busy", busy, 1);
        chk("restart_ignored_index", scan_index, 2);
        for (int k = 0; k < 200 && scan_index == 4'd2; k++) begin @(posedge clk); #1; end
        chk("index_continues", scan_index, 3);
      end
      @(posedge clk); #1;
      c++;
    end
    if (busy) chk("scan_timeout", 1, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_index(input int idx);
    int c = 0;
    while (scan_index != 4'(idx) && c < 3000) begin @(posedge clk); #1; c++; end
    if (scan_index != 4'(idx)) chk("wait_index_timeout", scan_index, idx);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 16; i++) dir_val[i] = v;
  endtask

  initial begin
    logic signed [21:0] r;
    set_all(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_delay", delay_select, 30);
    chk("rst_best_select", best_select, 30);
    chk("rst_best_energy", best_energy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    set_all(100); dir_val[6] = 1000;
    run_scan(0);

    set_all(-500);
    run_scan(0);

    set_all(0); dir_val[3] = -2097152;
    run_scan(0);

    // Establish best=15/4000, then abort the next scan mid-ACCUM at index 5.
    set_all(100); dir_val[6] = 1000;
    run_scan(0);
    for (int i = 0; i < 12; i++) dir_val[i] = $urandom_range(0, 60000);
    pulse_start();
    wait_index(5);
    repeat (20) @(posedge clk);
    #1; scan_abort = 1'b1;
    @(posedge clk); #1; scan_abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_delay", delay_select, 15);
    chk("abort_best_select", best_select, 15);
    chk("abort_best_energy", best_energy, 4000);
    repeat (60) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) dir_val[i] = int'($urandom_range(0, 4000)) - 2000;
    run_scan(1);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 12; i++) begin
        if (n % 2 == 0) begin
          r = 22'($urandom);
          dir_val[i] = r;
        end else begin
          dir_val[i] = (int'($urandom_range(0, 3)) - 1) * 300;
        end
      end
      run_scan(0);
    end

    // Reset during ACCUM of index 4: no done expected, outputs back to reset values.
    for (int i = 0; i < 12; i++) dir_val[i] = 777;
    pulse_start();
    wait_index(4);
    repeat (20) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_delay", delay_select, 30);
    chk("midrst_best_select", best_select, 30);
    chk("midrst_best_energy", best_energy, 0);
    chk("midrst_index", scan_index, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
